multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Sequential control unit for the multi-cycle MIPS datapath. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the datapath enables and mux selects cycle by cycle. It sits beside the shared instruction/data memory (IorD-multiplexed) and the IR/A/B/ALUOut/MDR registers, reading OpCode/Funct from the IR. It handles a MemReady wait handshake with a timeout.

Parameters:
MEM_TIMEOUT, 15, max consecutive MemReady-low wait cycles in one memory state before a fault; 0 disables the timeout.
TIMER_W, 4, width of the wait counter; must satisfy MEM_TIMEOUT < 2^TIMER_W.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
OpCode  input  6  IR[31:26].
Funct  input  6  IR[5:0].
MemReady  input  1  memory completes the current access this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load if ALU Zero.
IorD  output  1  memory address: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
IRWrite  output  1  IR load.
RegWrite  output  1  register file write.
RegDst  output  2  write register: 00 = rt, 01 = rd, 10 = $31.
MemtoReg  output  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
ALUSrcA  output  2  ALU A: 00 = PC, 01 = reg A, 10 = shamt.
ALUSrcB  output  2  ALU B: 00 = reg B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
ALUOp  output  3  000 add, 001 sub, 010 R-funct, 011 and, 100 slt, 101 sltu.
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.
ExtOp  output  1  1 = sign-extend, 0 = zero-extend.
LuOp  output  1  1 = imm<<16.
State  output  4  current state, for debug and the bench.
InstrDone  output  1  one-cycle pulse in an instruction's final state.
IllegalOp  output  1  one-cycle pulse for an unsupported opcode/funct.
MemFault  output  1  one-cycle pulse when the wait counter hits MEM_TIMEOUT.

Behaviour:
- Registered state. Outputs are combinational from State, OpCode, Funct and MemReady.
- Any output not listed for a state is 0. ExtOp defaults to 1.
- Reset: at a clk edge with reset = 0, State <= FETCH (0) and the wait counter <= 0.
- While reset = 0, every enable (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite) and every pulse output is forced to 0.
- Reset asserted mid-instruction abandons that instruction and raises no InstrDone.

States:
- 0 FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite=PCWrite=MemReady. Goes to DECODE when MemReady=1, otherwise stays.
- 1 DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by opcode:
  - lw/sw -> 2
  - R-type -> 6
  - addi/addiu/andi/slti/sltiu/lui -> 8
  - beq -> 10
  - j/jal -> 11
  - any other opcode -> IllegalOp=1, then FETCH.
- 2 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, add. lw -> 3, sw -> 5.
- 3 MEM_RD: MemRead=1, IorD=1. Goes to 4 on MemReady.
- 4 MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01, InstrDone. -> FETCH.
- 5 MEM_WR: MemWrite=1, IorD=1. On MemReady: InstrDone, -> FETCH.
- 6 EXEC_R: ALUSrcB=00, ALUOp=010. ALUSrcA=10 for Funct 00/02/03, otherwise 01. By Funct:
  - 0x08 (jr): PCWrite=1, PCSource=11, InstrDone, -> FETCH.
  - 0x09 (jalr): additionally RegWrite=1, RegDst=01, MemtoReg=10.
  - Funct outside {00,02,03,08,09,20-27,2A,2B}: IllegalOp, -> FETCH.
  - Otherwise -> 7.
- 7 WB_R: RegWrite=1, RegDst=01, MemtoReg=00, InstrDone. -> FETCH.
- 8 EXEC_I: ALUSrcA=01, ALUSrcB=10. ALUOp by opcode: add for addi/addiu/lui, and for andi, slt for slti, sltu for sltiu. ExtOp=0 for andi. LuOp=1 for lui. -> 9.
- 9 WB_I: RegWrite=1, RegDst=00, MemtoReg=00, InstrDone. -> FETCH.
- 10 BRANCH: ALUSrcA=01, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, InstrDone. -> FETCH.
- 11 JUMP: PCWrite=1, PCSource=10, InstrDone. For jal, also RegWrite=1, RegDst=10, MemtoReg=10. -> FETCH.
- Encodings 12-15 are unreachable. If entered, go to FETCH with IllegalOp.

Wait timer:
- Counts consecutive MemReady=0 cycles in states 0, 3 and 5; it clears on MemReady or on a state change.
- When the count equals MEM_TIMEOUT (nonzero): MemFault pulse, counter cleared.
  - FETCH stays in FETCH and retries.
  - MEM_RD/MEM_WR abort to FETCH with no RegWrite and no InstrDone.
- Latency with MemReady=1: R-type and I-type 4 cycles, lw 5, sw 4, beq/j/jal/jr 3.

Decomposition:
- Package multicycle_ctrl_pkg holds: state encodings; opcode/funct constants; ALUOp codes; RegDst/MemtoReg/ALUSrcA/ALUSrcB/PCSource select codes.
- One sub-module, mem_wait_timer: clk, reset, Waiting, Clear -> Expired.

Test Plan:
- add (Op 00, Funct 20), MemReady=1 -> State 0,1,6,7,0. RegWrite only in 7 with RegDst=01. InstrDone on the 4th cycle.
- lw with MemReady=0 for 3 cycles in MEM_RD -> State 3 held 4 cycles with MemRead=1 and IorD=1, then 4 with RegWrite=1 and MemtoReg=01.
- beq (Op 04) -> 0,1,10. In state 10: PCWriteCond=1, ALUOp=001, PCSource=01. Then jal (Op 03) -> state 11 with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
- Op 3F in DECODE -> IllegalOp pulse, back to FETCH, no RegWrite. Funct 3F in EXEC_R -> same.
- MEM_TIMEOUT=4, MemReady held 0 in MEM_WR -> MemFault pulse after 4 wait cycles, State=0, no InstrDone.
- reset=0 during MEM_WR -> at next edge State=0, and MemWrite=0 while reset is low.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operations and datapath mux select codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_SLTU  = 3'b101;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  function automatic logic funct_legal(input logic [5:0] f);
    return f inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
                     [6'h20:6'h27], FN_SLT, FN_SLTU};
  endfunction

  // Shift-by-immediate functs take the shift amount on ALU input A.
  function automatic logic funct_is_shift(input logic [5:0] f);
    return f inside {FN_SLL, FN_SRL, FN_SRA};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle in which the
// MEM_TIMEOUT-th consecutive wait occurs; MEM_TIMEOUT = 0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMER_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic Waiting,
  input  logic Clear,
  output logic Expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(MEM_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  assign Expired = (MEM_TIMEOUT != 0) && Waiting && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (Clear || Expired) begin
      cnt_d = '0;
    end else if (Waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction through fetch,
// decode, execute, memory and writeback, with a MemReady wait timeout.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMER_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic       MemFault
);

  state_t state_q, state_d;
  logic   waiting, expired;
  logic   pcw, pcwc, mrd, mwr, irw, rw, done, ill;

  assign waiting = !MemReady &&
                   (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TIMER_W    (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .Waiting(waiting),
    .Clear  (!waiting),
    .Expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    pcw      = 1'b0;
    pcwc     = 1'b0;
    mrd      = 1'b0;
    mwr      = 1'b0;
    irw      = 1'b0;
    rw       = 1'b0;
    done     = 1'b0;
    ill      = 1'b0;
    IorD     = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALU;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REG;
    ALUOp    = ALU_ADD;
    PCSource = PCSRC_ALU;
    ExtOp    = 1'b1;
    LuOp     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mrd     = 1'b1;
        ALUSrcB = SRCB_FOUR;
        irw     = MemReady;
        pcw     = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (OpCode)
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_RTYPE:                state_d = S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ:                  state_d = S_BRANCH;
          OP_J, OP_JAL:            state_d = S_JUMP;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        state_d = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mrd  = 1'b1;
        IorD = 1'b1;
        if (expired)       state_d = S_FETCH;
        else if (MemReady) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        rw       = 1'b1;
        MemtoReg = M2R_MDR;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mwr  = 1'b1;
        IorD = 1'b1;
        if (MemReady) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end else if (expired) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = funct_is_shift(Funct) ? SRCA_SHAMT : SRCA_REG;
        ALUOp   = ALU_FUNCT;
        if (Funct == FN_JR || Funct == FN_JALR) begin
          pcw      = 1'b1;
          PCSource = PCSRC_REGA;
          done     = 1'b1;
          state_d  = S_FETCH;
          if (Funct == FN_JALR) begin
            rw       = 1'b1;
            RegDst   = REGDST_RD;
            MemtoReg = M2R_PC;
          end
        end else if (!funct_legal(Funct)) begin
          ill     = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_WB_R: begin
        rw      = 1'b1;
        RegDst  = REGDST_RD;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        case (OpCode)
          OP_ANDI:  ALUOp = ALU_AND;
          OP_SLTI:  ALUOp = ALU_SLT;
          OP_SLTIU: ALUOp = ALU_SLTU;
          default:  ALUOp = ALU_ADD;
        endcase
        ExtOp   = (OpCode != OP_ANDI);
        LuOp    = (OpCode == OP_LUI);
        state_d = S_WB_I;
      end
      S_WB_I: begin
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_REG;
        ALUOp    = ALU_SUB;
        pcwc     = 1'b1;
        PCSource = PCSRC_ALUOUT;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcw      = 1'b1;
        PCSource = PCSRC_JUMP;
        done     = 1'b1;
        state_d  = S_FETCH;
        if (OpCode == OP_JAL) begin
          rw       = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      default: begin
        ill     = 1'b1;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Enables and pulses are held low for the whole time reset is asserted.
  assign PCWrite     = reset & pcw;
  assign PCWriteCond = reset & pcwc;
  assign MemRead     = reset & mrd;
  assign MemWrite    = reset & mwr;
  assign IRWrite     = reset & irw;
  assign RegWrite    = reset & rw;
  assign InstrDone   = reset & done;
  assign IllegalOp   = reset & ill;
  assign MemFault    = reset & expired;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its expected per-cycle control sequence and compared cycle by cycle.
module tb_multicycle_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OpCode = '0;
  logic [5:0] Funct = '0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       ExtOp, LuOp, InstrDone, IllegalOp, MemFault;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO), .TIMER_W(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp), .State(State),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .MemFault(MemFault)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r, asa, asb;
    logic [2:0] aop;
    logic [1:0] psrc;
    logic ext, lu, done, ill, flt;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    exp_t       e;
  } step_t;

  typedef enum {K_R, K_JR, K_JALR, K_BADFN, K_LW, K_SW, K_IMM, K_BEQ, K_J, K_JAL, K_BADOP} kind_t;

  step_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return K_JR;
        if (fn == 6'h09) return K_JALR;
        if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) return K_R;
        return K_BADFN;
      end
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: return K_IMM;
      default: return K_BADOP;
    endcase
  endfunction

  function automatic exp_t rec(input int st);
    exp_t e = '0;
    e.st  = 4'(st);
    e.ext = 1'b1;
    return e;
  endfunction

  function automatic void push(input logic r, input logic [5:0] op, input logic [5:0] fn, input exp_t e);
    q.push_back({r, op, fn, e});
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction. wf/wm are the numbers
  // of MemReady-low cycles offered in FETCH and in the memory access state.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    kind_t k = classify(op, fn);
    exp_t  e;
    int    cnt = 0;
    bit    aborted = 0;
    logic  rnd;
    for (int i = 0; i < wf; i++) begin
      cnt++;
      e = rec(0); e.mrd = 1; e.asb = 2'd1;
      if (cnt == TO) begin e.flt = 1; cnt = 0; end
      push(1'b0, op, fn, e);
    end
    e = rec(0); e.mrd = 1; e.asb = 2'd1; e.irw = 1; e.pcw = 1;
    push(1'b1, op, fn, e);
    e = rec(1); e.asb = 2'd3; e.ill = (k == K_BADOP);
    rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
    case (k)
      K_LW, K_SW: begin
        e = rec(2); e.asa = 2'd1; e.asb = 2'd2;
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
        cnt = 0;
        for (int i = 0; i < wm && !aborted; i++) begin
          cnt++;
          e = rec(k == K_LW ? 3 : 5); e.iord = 1;
          if (k == K_LW) e.mrd = 1; else e.mwr = 1;
          if (cnt == TO) begin e.flt = 1; aborted = 1; end
          push(1'b0, op, fn, e);
        end
        if (!aborted) begin
          e = rec(k == K_LW ? 3 : 5); e.iord = 1;
          if (k == K_LW) e.mrd = 1; else begin e.mwr = 1; e.done = 1; end
          push(1'b1, op, fn, e);
          if (k == K_LW) begin
            e = rec(4); e.rw = 1; e.m2r = 2'd1; e.done = 1;
            rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
          end
        end
      end
      K_R, K_JR, K_JALR, K_BADFN: begin
        e = rec(6); e.aop = 3'd2;
        e.asa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
        if (k == K_JR || k == K_JALR) begin e.pcw = 1; e.psrc = 2'd3; e.done = 1; end
        if (k == K_JALR) begin e.rw = 1; e.rdst = 2'd1; e.m2r = 2'd2; end
        if (k == K_BADFN) e.ill = 1;
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
        if (k == K_R) begin
          e = rec(7); e.rw = 1; e.rdst = 2'd1; e.done = 1;
          rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
        end
      end
      K_IMM: begin
        e = rec(8); e.asa = 2'd1; e.asb = 2'd2;
        e.aop = (op == 6'h0C) ? 3'd3 : (op == 6'h0A) ? 3'd4 : (op == 6'h0B) ? 3'd5 : 3'd0;
        e.ext = (op != 6'h0C); e.lu = (op == 6'h0F);
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
        e = rec(9); e.rw = 1; e.done = 1;
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
      end
      K_BEQ: begin
        e = rec(10); e.asa = 2'd1; e.aop = 3'd1; e.pcwc = 1; e.psrc = 2'd1; e.done = 1;
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
      end
      K_J, K_JAL: begin
        e = rec(11); e.pcw = 1; e.psrc = 2'd2; e.done = 1;
        if (k == K_JAL) begin e.rw = 1; e.rdst = 2'd2; e.m2r = 2'd2; end
        rnd = 1'($urandom_range(0, 1)); push(rnd, op, fn, e);
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.st = State; a.pcw = PCWrite; a.pcwc = PCWriteCond; a.iord = IorD;
    a.mrd = MemRead; a.mwr = MemWrite; a.irw = IRWrite; a.rw = RegWrite;
    a.rdst = RegDst; a.m2r = MemtoReg; a.asa = ALUSrcA; a.asb = ALUSrcB;
    a.aop = ALUOp; a.psrc = PCSource; a.ext = ExtOp; a.lu = LuOp;
    a.done = InstrDone; a.ill = IllegalOp; a.flt = MemFault;
    return a;
  endfunction

  task automatic test_reset();
    reset = 1'b0; MemReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin
      errors++; $display("FAIL reset_state got %0d expected 0", State);
    end
    checks++;
    if ({PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, InstrDone, IllegalOp, MemFault} !== 9'd0) begin
      errors++;
      $display("FAIL reset_enables got %b expected 000000000",
               {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, InstrDone, IllegalOp, MemFault});
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    step_t s; exp_t a; int n = 0;
    build(6'h00, 6'h20, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL add cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    step_t s; exp_t a; int n = 0;
    build(6'h23, 6'h00, 1, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL lw_wait cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq_jal();
    step_t s; exp_t a; int n = 0;
    build(6'h04, 6'h15, 0, 0);
    build(6'h03, 6'h00, 0, 0);
    build(6'h02, 6'h00, 0, 0);
    build(6'h00, 6'h08, 0, 0);
    build(6'h00, 6'h09, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL branch_jump cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t s; exp_t a; int n = 0;
    build(6'h3F, 6'h20, 0, 0);
    build(6'h00, 6'h3F, 0, 0);
    build(6'h0C, 6'h00, 0, 0);
    build(6'h0F, 6'h00, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL illegal cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s; exp_t a; int n = 0;
    build(6'h2B, 6'h00, 0, 6);
    build(6'h23, 6'h00, 0, 4);
    build(6'h00, 6'h20, 5, 0);
    build(6'h2B, 6'h00, 0, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL timeout cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t s; exp_t a; int n = 0;
    build(6'h2B, 6'h00, 0, 0);
    while (q.size() > 1) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin errors++; $display("FAIL reset_mid cyc%0d got %h expected %h", n, a, s.e); end
      @(posedge clk); #1;
    end
    q.delete();
    MemReady = 1'b0;
    @(negedge clk);
    checks++;
    if ({State, MemWrite} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL reset_mid_memwr got state %0d MemWrite %b expected state 5 MemWrite 1", State, MemWrite);
    end
    reset = 1'b0; MemReady = 1'b1;
    #1;
    checks++;
    if ({MemWrite, InstrDone, RegWrite} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_gated got MemWrite %b InstrDone %b RegWrite %b expected 000", MemWrite, InstrDone, RegWrite);
    end
    @(posedge clk); #1;
    checks++;
    if (State !== 4'd0) begin
      errors++; $display("FAIL reset_mid_state got %0d expected 0", State);
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[15] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A,
                             6'h0B, 6'h0C, 6'h0F, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0] fns[14] = '{6'h20, 6'h21, 6'h24, 6'h27, 6'h2A, 6'h2B, 6'h00,
                             6'h02, 6'h03, 6'h08, 6'h09, 6'h3F, 6'h1C, 6'h05};
    logic [5:0] op, fn;
    step_t s; exp_t a; int n = 0;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 14)];
      fn = fns[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      build(op, fn, $urandom_range(0, 2) == 0 ? $urandom_range(0, 5) : 0, $urandom_range(0, 5));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); OpCode = s.op; Funct = s.fn; MemReady = s.rdy;
      @(negedge clk); a = sample(); checks++; n++;
      if (a !== s.e) begin
        errors++; $display("FAIL random cyc%0d op %h fn %h got %h expected %h", n, s.op, s.fn, a, s.e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq_jal();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
